sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Responder side of the memory-access-stage data interface.
- Accepts single-word read/write requests, services each as two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low to freeze the pipeline until the word completes.
- Sits between the memory-access stage (or cache miss path) and the SRAM pins.

Parameters:
- WAIT_CYCLES, 2, cycles each 16-bit half is held on the SRAM bus (legal 1..15)
- BASE_ADDR, 1024, byte address mapped to SRAM word 0
- SRAM_AW, 18, SRAM address width (16-bit locations)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- MEM_R_EN  input  1  read request, held until ready=1
- MEM_W_EN  input  1  write request, held until ready=1
- address  input  32  byte address; bits [1:0] ignored
- writeData  input  32  write word
- readData  output  32  read word, valid while ready=1 in DONE after a read
- ready  output  1  0 = stall pipeline
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  SRAM_AW  SRAM address
- SRAM_WE_N  output  1  write strobe, active low
- SRAM_OE_N  output  1  output enable, active low
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0

Behaviour:
- Clock/reset (already decided): one clock clk; rst is asynchronous, active-low.
- Reset values: state=IDLE, readData=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_OE_N=1, DQ high-Z, wait counter=0.
- Reset mid-access aborts the access; no partial-write recovery.
- Word mapping: w = (address - BASE_ADDR) >> 2.
  - Low half at SRAM_ADDR = {w,1'b0}, holds bits [15:0].
  - High half at {w,1'b1}, holds bits [31:16].
  - Truncate to SRAM_AW; no range check.
- ready is combinational: 1 in IDLE with no request; 0 in IDLE with a request and in LO/HI; 1 in DONE.
- States:
  - IDLE: on MEM_W_EN|MEM_R_EN, latch op/address/writeData and go to LO. If both enables are high, write wins and the read is dropped.
  - LO: drive the low-half address. Write: DQ=writeData[15:0], WE_N=0, OE_N=1. Read: DQ=Z, OE_N=0, WE_N=1. Stay WAIT_CYCLES cycles. On the last cycle's edge, a read captures DQ into readData[15:0]. Then go to HI.
  - HI: same as LO for the high half, capturing into readData[31:16]. Then go to DONE.
  - DONE: one cycle; WE_N=1, OE_N=1, DQ=Z; ready=1. Always go to IDLE. Requests in DONE are ignored: the pipeline advances on this edge, so enables next cycle belong to a new instruction.
- Latency: request at cycle 0 gives ready=0 for cycles 0..2*WAIT_CYCLES and ready=1 at cycle 2*WAIT_CYCLES+1. WAIT_CYCLES=2 gives a 6-cycle access.
- Back-to-back requests are re-accepted in IDLE the cycle after DONE.
- SRAM_ADDR, WE_N, OE_N and the DQ output enable are registered (glitch-free). WE_N is deasserted in DONE so the final write data is held through the rising WE_N.
- Latched request fields are immune to input changes during LO/HI.
- readData holds its last value until the next read captures.

Optional Feature:
- SRAM_CTRL_STATS_EN. When defined, adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments by 1 in DONE for its op type; wraps at 2^32.
  - Reset to 0.
- Without the macro, the ports and counters are absent.

Decomposition:
- Package sram_ctrl_pkg: state encoding (IDLE, LO, HI, DONE), op type (OP_RD, OP_WR), default WAIT_CYCLES/BASE_ADDR/SRAM_AW constants.
- Natural sub-module: sram_ctrl_stats (the two counters, instantiated only under SRAM_CTRL_STATS_EN).
- FSM, wait counter and DQ tri-state stay in the top module.

Test Plan:
- Write 0xDEADBEEF at 1024, WAIT_CYCLES=2 -> ready low for 5 cycles. SRAM_ADDR=0 with DQ=0xBEEF, WE_N=0 for 2 cycles, then SRAM_ADDR=1 with DQ=0xDEAD for 2 cycles. ready=1 on cycle 5.
- Read 1024 after the write, SRAM model returning stored data -> readData=0xDEADBEEF with ready=1 on cycle 5. OE_N low during both halves.
- Both enables high at address 1028 with writeData=0x12345678 -> write only to SRAM_ADDR 2/3; OE_N stays 1.
- Back-to-back read 1032 then write 1036 -> second access starts the cycle after DONE. No duplicate access; exactly 12 cycles total.
- rst pulled low during the HI phase of a write -> next cycle WE_N=1, DQ=Z, state IDLE, readData=0. A new read after release completes normally.
- With SRAM_CTRL_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2. Without the macro, the bench compiles with the ports absent.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: state/op encodings, default parameters and address helper for sram_controller
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_BASE_ADDR = 1024;
  localparam int DEF_SRAM_AW = 18;
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction
endpackage

// File: rtl/sram_ctrl_stats.sv
// sram_ctrl_stats: completed read/write counters (clk, rst active-low async; done/is_wr in; rd_count/wr_count out)
module sram_ctrl_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic        is_wr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= rd_count + {31'd0, done && !is_wr};
      wr_count <= wr_count + {31'd0, done && is_wr};
    end
endmodule

// File: rtl/sram_controller.sv
// sram_controller: services 32-bit read/write requests as two 16-bit async SRAM accesses, stalling via ready
//   pipeline side: MEM_R_EN, MEM_W_EN, address, writeData in; readData, ready out
//   SRAM side: SRAM_DQ (inout), SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N/UB_N/LB_N (tied 0)
//   rst is asynchronous active-low
//   SRAM_CTRL_STATS_EN adds rd_count/wr_count outputs
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
`ifdef SRAM_CTRL_STATS_EN
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
`endif
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  state_t state, state_nxt;
  op_t op_q, op_in;
  logic [SRAM_AW-2:0] word_q, word_in;
  logic [31:0] word_full, wdata_q, rdata_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [SRAM_AW-1:0] addr_nxt;
  logic [15:0] dq_out, dq_out_nxt;
  logic dq_oe, dq_oe_nxt, we_n_nxt, oe_n_nxt, req, last, unused_word_bits;
  assign req = MEM_W_EN || MEM_R_EN;
  assign op_in = MEM_W_EN ? OP_WR : OP_RD;
  assign word_full = word_index(address, BASE_ADDR);
  assign word_in = word_full[SRAM_AW-2:0];
  assign unused_word_bits = ^word_full[31:SRAM_AW-1];
  assign last = cnt == 4'(WAIT_CYCLES - 1);
  assign ready = state == DONE || (state == IDLE && !req);
  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  // Bus controls are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    addr_nxt = SRAM_ADDR;
    we_n_nxt = SRAM_WE_N;
    oe_n_nxt = SRAM_OE_N;
    dq_oe_nxt = dq_oe;
    dq_out_nxt = dq_out;
    rdata_nxt = readData;
    case (state)
      IDLE: if (req) begin
        state_nxt = LO;
        cnt_nxt = '0;
        addr_nxt = {word_in, 1'b0};
        we_n_nxt = op_in != OP_WR;
        oe_n_nxt = op_in == OP_WR;
        dq_oe_nxt = op_in == OP_WR;
        dq_out_nxt = writeData[15:0];
      end
      LO: if (last) begin
        state_nxt = HI;
        cnt_nxt = '0;
        addr_nxt = {word_q, 1'b1};
        dq_out_nxt = wdata_q[31:16];
        rdata_nxt[15:0] = op_q == OP_RD ? SRAM_DQ : readData[15:0];
      end else cnt_nxt = cnt + 4'd1;
      HI: if (last) begin
        state_nxt = DONE;
        cnt_nxt = '0;
        we_n_nxt = 1'b1;
        oe_n_nxt = 1'b1;
        dq_oe_nxt = 1'b0;
        rdata_nxt[31:16] = op_q == OP_RD ? SRAM_DQ : readData[31:16];
      end else cnt_nxt = cnt + 4'd1;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_oe <= 1'b0;
      dq_out <= '0;
      readData <= '0;
      op_q <= OP_RD;
      word_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      SRAM_ADDR <= addr_nxt;
      SRAM_WE_N <= we_n_nxt;
      SRAM_OE_N <= oe_n_nxt;
      dq_oe <= dq_oe_nxt;
      dq_out <= dq_out_nxt;
      readData <= rdata_nxt;
      if (state == IDLE && req) begin
        op_q <= op_in;
        word_q <= word_in;
        wdata_q <= writeData;
      end
    end
`ifdef SRAM_CTRL_STATS_EN
  sram_ctrl_stats u_stats (
    .clk     (clk),
    .rst     (rst),
    .done    (state == DONE),
    .is_wr   (op_q == OP_WR),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );
`endif
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed table plus randomized checks of sram_controller against an SRAM and word-level memory model
module tb_sram_controller;
  localparam int W = 2;
  localparam int BASE = 1024;
  typedef struct {
    logic w;
    logic r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;
  logic clk, rst, MEM_R_EN, MEM_W_EN, ready;
  logic [31:0] address, writeData, readData;
  wire [15:0] sram_dq;
  logic [17:0] SRAM_ADDR;
  logic SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0] rd_count, wr_count;
`endif
  logic [15:0] mem [0:255] = '{default: 16'h0};
  int we_low = 0, oe_low = 0;
  int checks = 0, errors = 0;
  int rd_tally = 0, wr_tally = 0;
  logic [31:0] ref_mem [logic [31:0]];
  vec_t vecs [7];
  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(18)) dut (
    .clk      (clk),
    .rst      (rst),
    .MEM_R_EN (MEM_R_EN),
    .MEM_W_EN (MEM_W_EN),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .SRAM_DQ  (sram_dq),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N),
`ifdef SRAM_CTRL_STATS_EN
    .rd_count (rd_count),
    .wr_count (wr_count),
`endif
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );
  assign sram_dq = !SRAM_OE_N ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[7:0]] <= sram_dq;
      we_low <= we_low + 1;
    end
    if (!SRAM_OE_N) oe_low <= oe_low + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Called right after a rising edge with the controller idle; returns right after the edge that leaves DONE.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    int we0, oe0;
    logic [31:0] lo_addr;
    logic hi, seen;
    we0 = we_low;
    oe0 = oe_low;
    lo_addr = ((a - BASE) >> 2) * 2;
    seen = 1'b0;
    MEM_W_EN = w;
    MEM_R_EN = r;
    address = a;
    writeData = wd;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      chk("ready", 32'(ready), 32'(k == 2 * W + 1));
      if (k >= 1 && k <= 2 * W) begin
        hi = k > W;
        chk("sram_addr", 32'(SRAM_ADDR), lo_addr + 32'(hi));
        chk("we_n", 32'(SRAM_WE_N), 32'(!w));
        chk("oe_n", 32'(SRAM_OE_N), 32'(w));
        if (w) chk("dq_write", 32'(sram_dq), 32'(hi ? wd[31:16] : wd[15:0]));
        address = $urandom;
        writeData = $urandom;
      end
      if (ready) begin
        seen = 1'b1;
        chk("done_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("done_oe_n", 32'(SRAM_OE_N), 32'd1);
        if (!w) chk("read_data", readData, exp_rd);
      end else if (k == 39) chk("ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    chk("we_cycles", 32'(we_low - we0), w ? 32'(2 * W) : 32'd0);
    chk("oe_cycles", 32'(oe_low - oe0), w ? 32'd0 : 32'(2 * W));
    if (w) wr_tally++;
    else rd_tally++;
  endtask
  initial begin
    logic [31:0] a, key, wd, exp;
    logic w, r;
    longint t0;
    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1043, 32'h0000FFFF, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 32'd1040, 32'h0, 32'h0000FFFF};
    vecs[6] = '{1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 32'h0};
    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    address = '0;
    writeData = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_rdata", readData, 32'd0);
    chk("tied_ce_ub_lb", {29'd0, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) access(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].exp_rd);
    t0 = $time;
    access(1'b0, 1'b1, 32'd1032, 32'h0, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'd1036, 32'h0BADC0DE, 32'h0);
    chk("b2b_cycles", 32'(($time - t0) / 10), 32'd12);
    MEM_W_EN = 1'b1;
    address = 32'd1048;
    writeData = 32'h11112222;
    repeat (W + 2) @(negedge clk);
    chk("pre_rst_hi_addr", 32'(SRAM_ADDR), 32'd13);
    rst = 1'b0;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("abort_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_rdata", readData, 32'd0);
    chk("abort_addr", 32'(SRAM_ADDR), 32'd0);
    rst = 1'b1;
    rd_tally = 0;
    wr_tally = 0;
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
    for (int i = 0; i < 40; i++) begin
      a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      key = a & 32'hFFFF_FFFC;
      w = ($urandom_range(0, 1) == 1) || !ref_mem.exists(key);
      r = !w || ($urandom_range(0, 3) == 0);
      wd = $urandom;
      exp = w ? 32'h0 : ref_mem[key];
      access(w, r, a, wd, exp);
      if (w) ref_mem[key] = wd;
    end
`ifdef SRAM_CTRL_STATS_EN
    chk("rd_count", rd_count, 32'(rd_tally));
    chk("wr_count", wr_count, 32'(wr_tally));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
